// File: rtl/pp_cond_filter.sv
// pp_cond_filter: streaming filter for SystemVerilog conditional compilation.
// Removes `ifdef/`ifndef/`else/`endif directive text from a byte stream. It
// forwards the remaining bytes only while the enclosing conditional region is
// active. Every other backtick sequence passes through untouched.
//
// Ports:
//   i_clk, i_arstn           clock, asynchronous active-low reset
//   i_in_valid/o_in_ready    input byte handshake, i_in_data source byte
//   o_out_valid/i_out_ready  output byte handshake, o_out_data filtered byte
//   i_defined                macro-defined table indexed by 8-bit name hash
//   o_depth                  current nesting depth
//   o_err                    sticky error: 1 overflow, 2 stray else/endif,
//                            3 double else or bad name
module pp_cond_filter #(
    parameter int MAXDEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_arstn,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [7:0]   i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [7:0]   o_out_data,
    input  logic [255:0] i_defined,
    output logic [3:0]   o_depth,
    output logic [1:0]   o_err
);
    typedef enum logic [2:0] {
        S_PASS, S_TICK, S_NAME_WS, S_NAME, S_FLUSH, S_ERR
    } state_t;

    localparam logic [3:0] MAXD = 4'(MAXDEPTH);

    function automatic logic is_alpha(input logic [7:0] b);
        return (b >= "a" && b <= "z") || (b >= "A" && b <= "Z") || (b == "_");
    endfunction

    function automatic logic is_ident(input logic [7:0] b);
        return is_alpha(b) || (b >= "0" && b <= "9");
    endfunction

    // Keyword ids: 0 ifdef, 1 ifndef, 2 else, 3 endif.
    function automatic logic [2:0] kw_len(input int id);
        case (id)
            0:       return 3'd5;
            1:       return 3'd6;
            2:       return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [7:0] kw_char(input int id, input logic [2:0] pos);
        logic [47:0] s;
        case (id)
            0:       s = {"ifdef", 8'h00};
            1:       s = "ifndef";
            2:       s = {"else", 16'h0000};
            default: s = {"endif", 8'h00};
        endcase
        s = s << {pos, 3'b000};
        return s[47:40];
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  depth_q, depth_d;
    logic [1:0]  err_q, err_d;
    // Per-level stack: parent active, branch taken, `else already seen.
    logic [15:0] par_q, par_d, taken_q, taken_d, else_q, else_d;
    logic [7:0]  kbuf_q [8];
    logic [7:0]  kbuf_d [8];
    logic [2:0]  cnt_q, cnt_d, rd_q, rd_d;
    logic [3:0]  kwm_q, kwm_d;      // keywords still matching the buffer
    logic        ndef_q, ndef_d;
    logic [7:0]  hash_q, hash_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;

    logic        out_free, emit, in_rdy, cur_active, taken_new;
    logic [7:0]  emit_byte;
    logic [2:0]  k;
    logic [3:0]  ext, done;

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        err_d       = err_q;
        par_d       = par_q;
        taken_d     = taken_q;
        else_d      = else_q;
        kbuf_d      = kbuf_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        kwm_d       = kwm_q;
        ndef_d      = ndef_q;
        hash_d      = hash_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        emit        = 1'b0;
        emit_byte   = i_in_data;
        in_rdy      = 1'b0;
        out_free    = ~out_valid_q | i_out_ready;
        // At depth 0 the wrapped index selects junk, masked by the OR.
        cur_active  = (depth_q == 4'd0) |
                      (par_q[depth_q - 4'd1] &
                       (taken_q[depth_q - 4'd1] ^ else_q[depth_q - 4'd1]));
        taken_new   = ndef_q ? ~i_defined[hash_q] : i_defined[hash_q];
        k           = cnt_q - 3'd1;
        ext         = '0;
        done        = '0;
        for (int i = 0; i < 4; i++) begin
            ext[i]  = kwm_q[i] && (k < kw_len(i)) && (kw_char(i, k) == i_in_data);
            done[i] = kwm_q[i] && (k == kw_len(i));
        end

        case (state_q)
            S_PASS: begin
                in_rdy = out_free;
                if (i_in_valid && out_free) begin
                    if (i_in_data == 8'h60) begin
                        kbuf_d[0] = i_in_data;
                        cnt_d     = 3'd1;
                        kwm_d     = 4'hF;
                        state_d   = S_TICK;
                    end else begin
                        emit = cur_active;
                    end
                end
            end
            S_TICK: begin
                // Ready drops for bytes that end the keyword without being
                // consumed, so the handshake never claims a byte we keep.
                in_rdy = out_free;
                if (i_in_valid) begin
                    if (|ext) begin
                        if (out_free) begin
                            kbuf_d[cnt_q] = i_in_data;
                            cnt_d         = cnt_q + 3'd1;
                            kwm_d         = ext;
                        end
                    end else if ((done[0] | done[1]) && !is_ident(i_in_data)) begin
                        if (out_free) begin
                            ndef_d  = done[1];
                            state_d = S_NAME_WS;
                        end
                    end else if (done[2] && !is_ident(i_in_data)) begin
                        in_rdy = 1'b0;
                        if (depth_q == 4'd0) begin
                            err_d = 2'd2; state_d = S_ERR;
                        end else if (else_q[depth_q - 4'd1]) begin
                            err_d = 2'd3; state_d = S_ERR;
                        end else begin
                            else_d[depth_q - 4'd1] = 1'b1;
                            state_d = S_PASS;
                        end
                    end else if (done[3] && !is_ident(i_in_data)) begin
                        in_rdy = 1'b0;
                        if (depth_q == 4'd0) begin
                            err_d = 2'd2; state_d = S_ERR;
                        end else begin
                            depth_d = depth_q - 4'd1;
                            state_d = S_PASS;
                        end
                    end else begin
                        in_rdy  = 1'b0;
                        rd_d    = 3'd0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_NAME_WS: begin
                in_rdy = out_free;
                if (i_in_valid && out_free) begin
                    if (i_in_data == " " || i_in_data == 8'h09) begin
                        state_d = S_NAME_WS;
                    end else if (is_alpha(i_in_data)) begin
                        hash_d  = i_in_data;
                        state_d = S_NAME;
                    end else begin
                        err_d = 2'd3; state_d = S_ERR;
                    end
                end
            end
            S_NAME: begin
                in_rdy = out_free;
                if (i_in_valid) begin
                    if (is_ident(i_in_data)) begin
                        if (out_free) hash_d = {hash_q[6:0], hash_q[7]} ^ i_in_data;
                    end else begin
                        // Terminator stays on the input for PASS to handle.
                        in_rdy = 1'b0;
                        if (depth_q == MAXD) begin
                            err_d = 2'd1; state_d = S_ERR;
                        end else begin
                            par_d[depth_q]   = cur_active;
                            taken_d[depth_q] = taken_new;
                            else_d[depth_q]  = 1'b0;
                            depth_d          = depth_q + 4'd1;
                            state_d          = S_PASS;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    emit      = cur_active;
                    emit_byte = kbuf_q[rd_q];
                    rd_d      = rd_q + 3'd1;
                    if (rd_q == cnt_q - 3'd1) state_d = S_PASS;
                end
            end
            S_ERR: in_rdy = 1'b1;
            default: state_d = S_ERR;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_byte;
        end else if (i_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q     <= S_PASS;
            depth_q     <= '0;
            err_q       <= '0;
            par_q       <= '0;
            taken_q     <= '0;
            else_q      <= '0;
            kbuf_q      <= '{default: 8'h00};
            cnt_q       <= '0;
            rd_q        <= '0;
            kwm_q       <= '0;
            ndef_q      <= 1'b0;
            hash_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            par_q       <= par_d;
            taken_q     <= taken_d;
            else_q      <= else_d;
            kbuf_q      <= kbuf_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            kwm_q       <= kwm_d;
            ndef_q      <= ndef_d;
            hash_q      <= hash_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign o_in_ready  = i_arstn & in_rdy;
    assign o_out_valid = out_valid_q;
    assign o_out_data  = out_data_q;
    assign o_depth     = depth_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_pp_cond_filter.sv
// Bench for pp_cond_filter: directed cases plus random token streams checked
// against a text-level reference of the conditional-compilation rules.
module tb_pp_cond_filter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready, sel;
    logic [7:0]   in_data;
    logic [255:0] defined;
    logic         rdy1, rdy2, ov1, ov2;
    logic [7:0]   od1, od2;
    logic [3:0]   dp1, dp2;
    logic [1:0]   er1, er2;
    logic         s_rdy, s_ov;
    logic [7:0]   s_od;
    logic [3:0]   s_depth;
    logic [1:0]   s_err;

    int checks = 0, failures = 0, last_low;
    logic [7:0] stim[$], exp_q[$], got[$];
    int exp_depth, exp_err;

    string toks [0:17] = '{"`ifdef A ", "`ifndef B\n", "`ifdef\tAB_1;", "`else ",
        "`endif\n", "`else\n", "x", "hello ", "`define Z 1\n", "`ifdefx ",
        "`elsewhere;", "`endi\n", "``x", "`ifdef 9\n", "`ifndef  A\n", "\n",
        "`endif;", "`ifdef A\n"};

    always #5 clk = ~clk;

    pp_cond_filter dut (
        .i_clk(clk), .i_arstn(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
        .i_in_data(in_data), .o_out_valid(ov1), .i_out_ready(out_ready),
        .o_out_data(od1), .i_defined(defined), .o_depth(dp1), .o_err(er1));

    pp_cond_filter #(.MAXDEPTH(2)) dut2 (
        .i_clk(clk), .i_arstn(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy2),
        .i_in_data(in_data), .o_out_valid(ov2), .i_out_ready(out_ready),
        .o_out_data(od2), .i_defined(defined), .o_depth(dp2), .o_err(er2));

    assign s_rdy   = sel ? rdy2 : rdy1;
    assign s_ov    = sel ? ov2  : ov1;
    assign s_od    = sel ? od2  : od1;
    assign s_depth = sel ? dp2  : dp1;
    assign s_err   = sel ? er2  : er1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_alpha(input logic [7:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || c == "_";
    endfunction

    function automatic bit tb_ident(input logic [7:0] c);
        return tb_alpha(c) || (c >= "0" && c <= "9");
    endfunction

    task automatic add(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic load(input string s);
        stim.delete();
        add(s);
    endtask

    // Text-level reference: look ahead over whole words after each backtick.
    task automatic model(input int maxd);
        int i, j, n, err;
        logic [7:0] h;
        bit cur;
        string kw;
        bit par_s[$], tak_s[$], els_s[$];
        exp_q.delete();
        i = 0; n = stim.size(); err = 0;
        while (i < n && err == 0) begin
            cur = (par_s.size() == 0) ? 1'b1 :
                  (par_s[$] & (els_s[$] ? !tak_s[$] : tak_s[$]));
            if (stim[i] != 8'h60) begin
                if (cur) exp_q.push_back(stim[i]);
                i++;
                continue;
            end
            j = i + 1;
            while (j < n && tb_ident(stim[j])) j++;
            kw = "";
            if (j < n) for (int m = i + 1; m < j; m++) kw = $sformatf("%s%c", kw, stim[m]);
            if (kw == "ifdef" || kw == "ifndef") begin
                i = j + 1;
                while (i < n && (stim[i] == " " || stim[i] == 8'h09)) i++;
                if (i >= n) break;
                if (!tb_alpha(stim[i])) begin err = 3; break; end
                h = 0;
                while (i < n && tb_ident(stim[i])) begin
                    h = ((h << 1) | (h >> 7)) ^ stim[i];
                    i++;
                end
                if (i >= n) break;
                if (par_s.size() == maxd) begin err = 1; break; end
                par_s.push_back(cur);
                tak_s.push_back((kw == "ifdef") ? defined[h] : !defined[h]);
                els_s.push_back(1'b0);
            end else if (kw == "else") begin
                if (par_s.size() == 0) begin err = 2; break; end
                if (els_s[$]) begin err = 3; break; end
                els_s[els_s.size() - 1] = 1'b1;
                i = j;
            end else if (kw == "endif") begin
                if (par_s.size() == 0) begin err = 2; break; end
                void'(par_s.pop_back());
                void'(tak_s.pop_back());
                void'(els_s.pop_back());
                i = j;
            end else begin
                if (cur) exp_q.push_back(8'h60);
                i++;
            end
        end
        exp_depth = par_s.size();
        exp_err   = err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input string tag, input int rdy_pct);
        int idx = 0, cyc = 0, idle = 0, stall_err = 0, low = 0, nmin;
        got.delete();
        while (cyc < stim.size() * 20 + 100 && !(idx == stim.size() && idle >= 8)) begin
            @(negedge clk);
            in_valid  = (idx < stim.size());
            in_data   = in_valid ? stim[idx] : 8'h00;
            out_ready = ($urandom_range(99) < rdy_pct);
            #3;
            if (in_valid && !s_rdy) low++;
            if (s_err != 2'd0 && !s_rdy) stall_err++;
            if (s_ov && out_ready) got.push_back(s_od);
            if (in_valid && s_rdy) idx++;
            if (idx == stim.size() && !s_ov) idle++; else idle = 0;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        last_low = low;
        chk({tag, "_consumed"}, idx, stim.size());
        chk({tag, "_nbytes"}, got.size(), exp_q.size());
        nmin = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        chk({tag, "_depth"}, s_depth, exp_depth);
        chk({tag, "_err"}, s_err, exp_err);
        chk({tag, "_err_ready"}, stall_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ntok;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        sel = 1'b0; defined = '0;
        #2;
        chk("rst_out_valid", s_ov, 0);
        chk("rst_in_ready", s_rdy, 0);
        chk("rst_depth", s_depth, 0);
        chk("rst_err", s_err, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rel_in_ready", s_rdy, 1);

        // Defined branch taken.
        defined[8'h41] = 1'b1;
        load("`ifdef A\nx\n`else\ny\n`endif\n");
        exp_q = '{8'h0A, 8'h78, 8'h0A, 8'h0A}; exp_depth = 0; exp_err = 0;
        run_stream("def", 100);

        // Undefined: else branch taken.
        defined = '0; do_reset;
        load("`ifdef A\nx\n`else\ny\n`endif\n");
        exp_q = '{8'h0A, 8'h79, 8'h0A, 8'h0A};
        run_stream("undef", 100);

        // Non-directive replay: one reject cycle plus six flush cycles.
        do_reset;
        load("`ifdefx;");
        exp_q = '{8'h60, "i", "f", "d", "e", "f", "x", ";"};
        run_stream("flush", 100);
        chk("flush_ready_low", last_low, 7);

        // Overflow on the depth-2 instance.
        sel = 1'b1; defined = '1; do_reset;
        load("`ifdef A\n`ifdef A\n`ifdef A\nabc");
        exp_q = '{8'h0A, 8'h0A}; exp_depth = 2; exp_err = 1;
        run_stream("ovf", 100);
        sel = 1'b0; defined = '0;

        do_reset;
        load("`endif\n");
        exp_q.delete(); exp_depth = 0; exp_err = 2;
        run_stream("stray", 100);

        do_reset;
        load("`ifdef A `else `else ");
        exp_q = '{8'h20}; exp_depth = 1; exp_err = 3;
        run_stream("dbl_else", 100);

        // Back-pressure must not lose or duplicate bytes.
        defined[8'h41] = 1'b1; do_reset;
        load("`ifdef A\nx\n`else\ny\n`endif\n");
        exp_q = '{8'h0A, 8'h78, 8'h0A, 8'h0A}; exp_depth = 0; exp_err = 0;
        run_stream("bp", 50);

        // Asynchronous reset in the middle of a keyword.
        do_reset;
        load("`ifdef A\nz");
        exp_q = '{8'h0A, 8'h7A}; exp_depth = 1; exp_err = 0;
        run_stream("pre_rst", 100);
        @(negedge clk); in_valid = 1'b1; in_data = 8'h60; out_ready = 1'b1;
        @(negedge clk); in_data = "i";
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midtick_depth", s_depth, 0);
        chk("midtick_ready", s_rdy, 0);
        chk("midtick_ov", s_ov, 0);
        chk("midtick_err", s_err, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("midtick_rel_ready", s_rdy, 1);
        load("x\n");
        exp_q = '{"x", 8'h0A}; exp_depth = 0; exp_err = 0;
        run_stream("post_rst", 100);

        // Random token streams on both depth configurations.
        for (int t = 0; t < 40; t++) begin
            sel = (t % 4 == 3);
            for (int w = 0; w < 8; w++) defined[w*32 +: 32] = $urandom;
            do_reset;
            stim.delete();
            ntok = $urandom_range(6, 20);
            for (int n = 0; n < ntok; n++) add(toks[$urandom_range(17)]);
            add("\n");
            model(sel ? 2 : 8);
            run_stream($sformatf("rnd%0d", t), $urandom_range(30, 100));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
